// File: rtl/stream_regfile_mp_pkg.sv
// Shared types and defaults for the streaming polynomial register file.
//   coeff_t        one RNS residue
//   NREG/NCOEFF/NPRIMES  default geometry for instances of stream_regfile_mp
//   rf_state_e     op sequencer states
//   idx_w()        index width that never collapses to zero bits
package stream_regfile_mp_pkg;

  localparam int unsigned COEFF_W = 16;
  typedef logic [COEFF_W-1:0] coeff_t;

  localparam int unsigned NREG    = 4;
  localparam int unsigned NCOEFF  = 8;
  localparam int unsigned NPRIMES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rf_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_regfile_mp_rf_beat_mem.sv
// Beat-organised polynomial storage: DEPTH words of WIDTH bits.
//   clk            clock
//   ren/raddr      NRD independent read ports; rdata is registered and only
//                  updates when its ren is high, so it holds while stalled
//   we/waddr/wdata single write port (host load or FU result)
// A read of the address being written in the same cycle returns the new data.
module stream_regfile_mp_rf_beat_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = 5
) (
  input  logic                      clk,
  input  logic [NRD-1:0]            ren,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][WIDTH-1:0] rdata,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [WIDTH-1:0]          wdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NRD; i++) begin
      if (ren[i]) rdata[i] <= (we && (waddr == raddr[i])) ? wdata : mem[raddr[i]];
    end
  end

endmodule

// File: rtl/stream_regfile_mp.sv
// Multi-source streaming register file. Each register is one RNS polynomial
// stored as NBEATS beats of LANES residues (element e = c*NPRIMES_P + p,
// lane 0 lowest). An op streams up to NSRC source registers to an FU and
// writes the FU result stream back into a destination register.
//   clk, reset              clock, async active-high reset
//   rf_ready                idle and able to accept start / host writes
//   start, src_idx, src_en, dst_idx   op request
//   src_valid/data/last/ready         source streams (lockstep)
//   dst_valid/data/last, dst_ready    result stream
//   done                    one-cycle pulse at op completion
//   len_err                 sticky: dst_last seen on a non-final beat
//   host_we/reg/beat/data   host load port, honoured only when rf_ready
module stream_regfile_mp
  import stream_regfile_mp_pkg::*;
#(
  parameter  int unsigned NREG_P    = NREG,
  parameter  int unsigned NCOEFF_P  = NCOEFF,
  parameter  int unsigned NPRIMES_P = NPRIMES,
  parameter  int unsigned LANES     = 1,
  parameter  int unsigned NSRC      = 2,
  localparam int unsigned NBEATS    = NCOEFF_P * NPRIMES_P / LANES,
  localparam int unsigned RW        = idx_w(NREG_P),
  localparam int unsigned BW        = idx_w(NBEATS)
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            rf_ready,
  input  logic                            start,
  input  logic [NSRC-1:0][RW-1:0]         src_idx,
  input  logic [NSRC-1:0]                 src_en,
  input  logic [RW-1:0]                   dst_idx,
  output logic [NSRC-1:0]                 src_valid,
  output coeff_t [NSRC-1:0][LANES-1:0]    src_data,
  output logic [NSRC-1:0]                 src_last,
  input  logic [NSRC-1:0]                 src_ready,
  input  logic                            dst_valid,
  input  coeff_t [LANES-1:0]              dst_data,
  input  logic                            dst_last,
  output logic                            dst_ready,
  output logic                            done,
  output logic                            len_err,
  input  logic                            host_we,
  input  logic [RW-1:0]                   host_reg,
  input  logic [BW-1:0]                   host_beat,
  input  coeff_t [LANES-1:0]              host_data
);

  if ((NCOEFF_P * NPRIMES_P) % LANES != 0) begin : g_lanes_chk
    $error("LANES must divide NCOEFF_P*NPRIMES_P");
  end
  if (NSRC < 1 || NSRC > 3) begin : g_nsrc_chk
    $error("NSRC must be in 1..3");
  end

  typedef coeff_t [LANES-1:0] lane_vec_t;

  localparam int unsigned PW    = $clog2(NBEATS + 1);
  localparam int unsigned DEPTH = NREG_P * NBEATS;
  localparam int unsigned AW    = idx_w(DEPTH);
  localparam int unsigned LW    = $bits(lane_vec_t);
  localparam logic [PW-1:0] BEATS_PW = PW'(NBEATS);

  rf_state_e state, state_n;

  logic [NSRC-1:0][RW-1:0] src_q;
  logic [NSRC-1:0]         en_q;
  logic [RW-1:0]           dst_q;
  // rd_ptr counts source beats handed over; wr_ptr counts result beats written
  logic [PW-1:0]           rd_ptr, wr_ptr, rd_next;
  logic                    vld_q, last_q, rdy_q, done_q, err_q;

  logic                    accept, src_go, dst_go, last_wr, dst_rdy_c;
  logic [NSRC-1:0]         ren;
  logic [NSRC-1:0][AW-1:0] raddr;
  logic [NSRC-1:0][LW-1:0] rdata;
  logic                    we;
  logic [AW-1:0]           waddr;
  lane_vec_t               wdata;

  assign accept    = start && rdy_q;
  assign src_go    = vld_q && ((src_ready | ~en_q) == '1);
  // A result beat may only land on a beat whose source has already left,
  // which keeps in-place ops from overwriting unread data.
  assign dst_rdy_c = (state != ST_IDLE) && (wr_ptr < rd_ptr);
  assign dst_go    = dst_valid && dst_rdy_c;
  assign last_wr   = dst_go && (wr_ptr == BEATS_PW - PW'(1));
  assign rd_next   = rd_ptr + PW'(1);

  // Read ports: beat 0 is fetched on the accepting edge, later beats are
  // prefetched on each handshake so the output register never bubbles.
  always_comb begin
    ren   = '0;
    raddr = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (accept) begin
        ren[i]   = src_en[i];
        raddr[i] = AW'(src_idx[i]) * AW'(NBEATS);
      end else if (src_go && (rd_next < BEATS_PW)) begin
        ren[i]   = en_q[i];
        raddr[i] = AW'(src_q[i]) * AW'(NBEATS) + AW'(rd_next);
      end
    end
  end

  // Host writes only happen while idle and result writes only while busy,
  // so the shared write port never sees both.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (host_we && rdy_q) begin
      we    = 1'b1;
      waddr = AW'(host_reg) * AW'(NBEATS) + AW'(host_beat);
      wdata = host_data;
    end else if (dst_go) begin
      we    = 1'b1;
      waddr = AW'(dst_q) * AW'(NBEATS) + AW'(wr_ptr);
      wdata = dst_data;
    end
  end

  stream_regfile_mp_rf_beat_mem #(
    .DEPTH (DEPTH),
    .WIDTH (LW),
    .NRD   (NSRC),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_RUN;
      ST_RUN: begin
        if (last_wr) state_n = ST_IDLE;
        else if (src_go && (rd_next == BEATS_PW)) state_n = ST_DRAIN;
      end
      ST_DRAIN: if (last_wr) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      src_q  <= '0;
      en_q   <= '0;
      dst_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      rdy_q  <= (state_n == ST_IDLE);
      done_q <= last_wr;
      if (accept) begin
        src_q  <= src_idx;
        en_q   <= src_en;
        dst_q  <= dst_idx;
        rd_ptr <= '0;
        wr_ptr <= '0;
        vld_q  <= 1'b1;
        last_q <= (NBEATS == 1);
        err_q  <= 1'b0;
      end else begin
        if (src_go) begin
          rd_ptr <= rd_next;
          vld_q  <= (rd_next < BEATS_PW);
          last_q <= (rd_next == BEATS_PW - PW'(1));
        end
        if (dst_go) begin
          wr_ptr <= wr_ptr + PW'(1);
          if (dst_last && (wr_ptr != BEATS_PW - PW'(1))) err_q <= 1'b1;
        end
      end
    end
  end

  assign rf_ready  = rdy_q;
  assign src_valid = en_q & {NSRC{vld_q}};
  assign src_last  = en_q & {NSRC{vld_q && last_q}};
  assign src_data  = rdata;
  assign dst_ready = dst_rdy_c;
  assign done      = done_q;
  assign len_err   = err_q;

endmodule

// File: tb/tb_stream_regfile_mp.sv
module tb_stream_regfile_mp;
  import stream_regfile_mp_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NC = 8;
  localparam int unsigned NP = 2;
  localparam int unsigned L  = 2;
  localparam int unsigned NS = 2;
  localparam int unsigned NB = NC * NP / L;

  typedef coeff_t [L-1:0] lanes_t;
  typedef struct packed {
    lanes_t [NS-1:0] d;
    logic            last;
  } beat_t;

  logic                      clk, reset, rf_ready, start;
  logic [NS-1:0][1:0]        src_idx;
  logic [NS-1:0]             src_en, src_valid, src_last, src_ready;
  logic [1:0]                dst_idx, host_reg;
  coeff_t [NS-1:0][L-1:0]    src_data;
  logic                      dst_valid, dst_last, dst_ready, done, len_err, host_we;
  lanes_t                    dst_data, host_data;
  logic [2:0]                host_beat;

  stream_regfile_mp #(
    .NREG_P    (NR),
    .NCOEFF_P  (NC),
    .NPRIMES_P (NP),
    .LANES     (L),
    .NSRC      (NS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rf_ready  (rf_ready),
    .start     (start),
    .src_idx   (src_idx),
    .src_en    (src_en),
    .dst_idx   (dst_idx),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .dst_ready (dst_ready),
    .done      (done),
    .len_err   (len_err),
    .host_we   (host_we),
    .host_reg  (host_reg),
    .host_beat (host_beat),
    .host_data (host_data)
  );

  coeff_t  ref_mem [NR][NC][NP];
  beat_t   exp_q [$];
  lanes_t  fu_q [$];
  int      checks, errors;
  int      src_tot, dst_tot, done_cnt, last_at;
  logic [NS-1:0] cur_en;
  bit      gaps;
  bit      prev_stall;
  coeff_t [NS-1:0][L-1:0] prev_data;
  logic [NS-1:0] prev_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic coeff_t elem(input int r, input int e);
    return ref_mem[r][e / NP][e % NP];
  endfunction

  // Queue the expected source beats of an op and apply its result to the model.
  task automatic push_op(input logic [NS-1:0] en, input int s0, input int s1, input int d);
    int     s [NS];
    coeff_t res [NC][NP];
    beat_t  x;
    s[0] = s0;
    s[1] = s1;
    for (int b = 0; b < NB; b++) begin
      x.last = (b == NB - 1);
      for (int p = 0; p < NS; p++)
        for (int l = 0; l < L; l++)
          x.d[p][l] = en[p] ? elem(s[p], b * L + l) : '0;
      exp_q.push_back(x);
    end
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++) begin
        res[c][p] = '0;
        for (int k = 0; k < NS; k++)
          if (en[k]) res[c][p] = res[c][p] + ref_mem[s[k]][c][p];
      end
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++)
        ref_mem[d][c][p] = res[c][p];
  endtask

  // FU side: random source backpressure; results come out of a FIFO.
  always @(negedge clk) begin
    for (int p = 0; p < NS; p++) src_ready[p] = !gaps || ($urandom_range(3) != 0);
    if (fu_q.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
      dst_valid = 1'b1;
      dst_data  = fu_q[0];
      dst_last  = ((dst_tot % NB) == last_at);
    end else begin
      dst_valid = 1'b0;
      dst_data  = '0;
      dst_last  = 1'b0;
    end
  end

  // Monitor: checks every source handshake against the scoreboard and feeds the FU.
  always @(negedge clk) begin : monitor
    logic   go;
    beat_t  x;
    lanes_t r;
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("src_data_stable", src_data, prev_data);
        chk("src_valid_stable", src_valid, prev_valid);
      end
      chk("disabled_port_quiet", src_valid & ~cur_en, '0);
      go = (|(src_valid & cur_en)) && ((src_ready | ~cur_en) == '1);
      if (dst_ready) chk("dst_ready_vs_issued", dst_tot < src_tot, 1);
      if (dst_valid && dst_ready) begin
        if (fu_q.size() == 0) chk("dst_unexpected", 1, 0);
        else void'(fu_q.pop_front());
        dst_tot++;
      end
      if (go) begin
        if (exp_q.size() == 0) begin
          chk("src_unexpected", src_valid, 0);
        end else begin
          x = exp_q.pop_front();
          for (int p = 0; p < NS; p++)
            if (cur_en[p]) chk("src_data", src_data[p], x.d[p]);
          chk("src_last", src_last, cur_en & {NS{x.last}});
        end
        r = '0;
        for (int l = 0; l < L; l++)
          for (int p = 0; p < NS; p++)
            if (cur_en[p]) r[l] = r[l] + src_data[p][l];
        fu_q.push_back(r);
        src_tot++;
      end
      prev_stall = (|(src_valid & cur_en)) && !go;
      prev_data  = src_data;
      prev_valid = src_valid;
      if (done) done_cnt++;
    end
  end

  task automatic host_load(input int r);
    for (int b = 0; b < NB; b++) begin
      host_we   = 1'b1;
      host_reg  = 2'(r);
      host_beat = 3'(b);
      for (int l = 0; l < L; l++) host_data[l] = elem(r, b * L + l);
      @(negedge clk);
    end
    host_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rf_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rf_ready) chk("ready_timeout", rf_ready, 1);
  endtask

  task automatic wait_done(input int tgt);
    int n = 0;
    while (done_cnt < tgt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_count", done_cnt, tgt);
    repeat (3) @(negedge clk);
    #3;
    chk("done_once", done_cnt, tgt);
  endtask

  task automatic run_op(input logic [NS-1:0] en, input int s0, input int s1, input int d,
                        input int la, input bit inject);
    int tgt;
    wait_ready();
    @(negedge clk);
    last_at    = la;
    cur_en     = en;
    push_op(en, s0, s1, d);
    src_idx[0] = 2'(s0);
    src_idx[1] = 2'(s1);
    src_en     = en;
    dst_idx    = 2'(d);
    start      = 1'b1;
    tgt        = done_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    chk("first_src_valid", src_valid, en);
    if (inject) begin
      repeat (2) @(negedge clk);
      start     = 1'b1;
      src_idx   = '0;
      src_en    = 2'b11;
      dst_idx   = 2'd0;
      host_we   = 1'b1;
      host_reg  = 2'd0;
      host_beat = 3'd0;
      host_data = {16'hdead, 16'hbeef};
      @(negedge clk);
      start   = 1'b0;
      host_we = 1'b0;
    end
    wait_done(tgt);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rf_ready", rf_ready, 0);
    chk("rst_src_valid", src_valid, 0);
    chk("rst_src_last", src_last, 0);
    chk("rst_dst_ready", dst_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, n;
    checks = 0; errors = 0; src_tot = 0; dst_tot = 0; done_cnt = 0;
    last_at = NB - 1; cur_en = '0; gaps = 1'b0; prev_stall = 1'b0;
    reset = 1'b1; start = 1'b0; src_idx = '0; src_en = '0; dst_idx = '0;
    src_ready = '1; dst_valid = 1'b0; dst_data = '0; dst_last = 1'b0;
    host_we = 1'b0; host_reg = '0; host_beat = '0; host_data = '0;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++) begin
        ref_mem[0][c][p] = coeff_t'(c + p);
        ref_mem[1][c][p] = coeff_t'(4 * c + p + 10);
        ref_mem[2][c][p] = '0;
        ref_mem[3][c][p] = coeff_t'($urandom);
      end

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    chk("rf_ready_at_release", rf_ready, 0);
    @(negedge clk);
    chk("rf_ready_after_release", rf_ready, 1);

    for (int r = 0; r < NR; r++) host_load(r);

    // R0 + R1 -> R2 with no gaps, then again with random gaps, then read R2 back
    run_op(2'b11, 0, 1, 2, NB - 1, 0);
    chk("len_err_clean", len_err, 0);
    gaps = 1'b1;
    run_op(2'b11, 0, 1, 2, NB - 1, 0);
    run_op(2'b01, 2, 0, 2, NB - 1, 0);

    // unary in place, tightest FU turnaround, on each port
    gaps = 1'b0;
    run_op(2'b01, 3, 0, 3, NB - 1, 0);
    gaps = 1'b1;
    run_op(2'b10, 0, 1, 1, NB - 1, 0);

    // early dst_last: error is sticky until the next accepted start
    run_op(2'b11, 0, 1, 2, 2, 0);
    chk("len_err_set", len_err, 1);
    repeat (4) @(negedge clk);
    chk("len_err_sticky", len_err, 1);

    // start and host_we while busy are ignored; accepted start clears len_err
    run_op(2'b10, 0, 1, 1, NB - 1, 1);
    chk("len_err_cleared", len_err, 0);

    // reset in the middle of an op
    wait_ready();
    @(negedge clk);
    last_at = NB - 1;
    cur_en  = 2'b11;
    push_op(2'b11, 0, 1, 2);
    src_idx[0] = 2'd0; src_idx[1] = 2'd1; src_en = 2'b11; dst_idx = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk_reset_outputs();
    exp_q.delete();
    fu_q.delete();
    src_tot = 0;
    dst_tot = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rf_ready_at_release", rf_ready, 0);
    @(negedge clk);
    chk("abort_rf_ready_after_release", rf_ready, 1);
    host_load(2);

    // back-to-back ops with start held high
    wait_ready();
    @(negedge clk);
    cur_en = 2'b11;
    push_op(2'b11, 0, 1, 2);
    push_op(2'b11, 0, 1, 2);
    src_idx[0] = 2'd0; src_idx[1] = 2'd1; src_en = 2'b11; dst_idx = 2'd2;
    start = 1'b1;
    tgt = done_cnt + 2;
    @(negedge clk);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", done, 1);
    chk("b2b_ready_with_done", rf_ready, 1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_accepted", rf_ready, 0);
    chk("b2b_second_valid", src_valid, 2'b11);
    wait_done(tgt);

    run_op(2'b01, 2, 0, 2, NB - 1, 0);
    chk("queues_drained", exp_q.size() + fu_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
